// File: rtl/alu_dsub16_seq.sv
// alu_dsub16_seq
//   Two-pass 16-bit subtract sequencer driving an external combinational
//   8-bit subtractor (sub8b). The low byte goes first; its borrow-out feeds
//   the high-byte pass. Result and flags update together at the end of the
//   high pass and hold until the next operation completes.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   iStart          request, sampled only in IDLE
//   iMinu, iSubt    16-bit operands, captured on accept
//   iBorrow         initial borrow-in, captured on accept
//   oJ, oK, oB      operand bytes and borrow-in (oB[0]) to sub8b
//   iD, iBC         difference byte and borrow chain from sub8b
//   oResult         16-bit difference
//   oCY/oZ/oS/oV    borrow-out, zero, sign, signed overflow
//   oBusy, oDone    handshake: busy in LO/HI/DONE, one-cycle done pulse
module alu_dsub16_seq #(
   parameter int unsigned DATASIZE = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    iStart,
   input  logic [2*DATASIZE-1:0]   iMinu,
   input  logic [2*DATASIZE-1:0]   iSubt,
   input  logic                    iBorrow,
   output logic [DATASIZE-1:0]     oJ,
   output logic [DATASIZE-1:0]     oK,
   output logic [DATASIZE-1:0]     oB,
   input  logic [DATASIZE-1:0]     iD,
   input  logic [DATASIZE-1:0]     iBC,
   output logic [2*DATASIZE-1:0]   oResult,
   output logic                    oCY,
   output logic                    oZ,
   output logic                    oS,
   output logic                    oV,
   output logic                    oBusy,
   output logic                    oDone
);

   localparam int unsigned W = 2 * DATASIZE;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   state_t                state;
   logic [W-1:0]          minu;
   logic [W-1:0]          subt;
   logic [DATASIZE-1:0]   res_lo;
   logic                  bsave;

   // Only the top bit of the borrow chain is the pass borrow-out.
   logic unused_bc;
   assign unused_bc = ^iBC[DATASIZE-2:0];

   // The sub8b drive (oJ/oK/oB) is registered one edge ahead: it is loaded
   // on the edge that enters LO or HI, so it is valid for that whole state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         minu    <= '0;
         subt    <= '0;
         res_lo  <= '0;
         bsave   <= 1'b0;
         oJ      <= '0;
         oK      <= '0;
         oB      <= '0;
         oResult <= '0;
         oCY     <= 1'b0;
         oZ      <= 1'b0;
         oS      <= 1'b0;
         oV      <= 1'b0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               oDone <= 1'b0;
               if (iStart) begin
                  minu  <= iMinu;
                  subt  <= iSubt;
                  oJ    <= iMinu[DATASIZE-1:0];
                  oK    <= iSubt[DATASIZE-1:0];
                  oB    <= {{(DATASIZE-1){1'b0}}, iBorrow};
                  oBusy <= 1'b1;
                  state <= LO;
               end
            end
            LO: begin
               res_lo <= iD;
               bsave  <= iBC[DATASIZE-1];
               oJ     <= minu[W-1:DATASIZE];
               oK     <= subt[W-1:DATASIZE];
               oB     <= {{(DATASIZE-1){1'b0}}, iBC[DATASIZE-1]};
               state  <= HI;
            end
            HI: begin
               oResult <= {iD, res_lo};
               oCY     <= iBC[DATASIZE-1];
               oZ      <= ~|{iD, res_lo};
               oS      <= iD[DATASIZE-1];
               oV      <= (minu[W-1] ^ subt[W-1]) & (minu[W-1] ^ iD[DATASIZE-1]);
               oJ      <= '0;
               oK      <= '0;
               oB      <= '0;
               oDone   <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               oDone <= 1'b0;
               oBusy <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
